// File: rtl/sdio_pkg.sv
// Shared definitions for the SD clock controller: FSM state encoding and
// default values for the power-up clock count and the post-reset divider.
package sdio_pkg;

    localparam int         INIT_CLKS_DEF = 74;
    localparam logic [7:0] DIV_RESET_DEF = 8'd124;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LOAD  = 3'd3,
        ST_INIT  = 3'd4
    } state_t;

endpackage

// File: rtl/sdio_clk_ctrl.sv
// SD clock sequencer: safe divider changes, power-up clocks, optional flow-control pause.
// Optional feature macro: SDIO_CLK_AUTO_PAUSE_EN (auto-pause on FIFO full/empty while RUN).
//
// state | meaning
// IDLE  | clock stopped, waiting for software request
// RUN   | free-running SD clock
// DRAIN | enable dropped, waiting for generator to park the clock low
// LOAD  | new divider applied, clock still parked
// INIT  | clocking out the power-up edges
module sdio_clk_ctrl
    import sdio_pkg::*;
#(
    parameter int         INIT_CLKS = INIT_CLKS_DEF,
    parameter logic [7:0] DIV_RESET = DIV_RESET_DEF
) (
    input  logic       sd_clk,
    input  logic       rstn,
    input  logic       cfg_clk_en,
    input  logic [7:0] cfg_clk_div,
    input  logic       cfg_div_upd,
    input  logic       cfg_init_start,
    input  logic       gen_clk_oe,
    input  logic       gen_rx_en,
    input  logic       rx_active,
    input  logic       tx_active,
    input  logic       rx_fifo_full,
    input  logic       tx_fifo_empty,
    output logic       sd_clk_en,
    output logic [7:0] sd_clk_div,
    output logic       sd_clk_pause,
    output logic       upd_done,
    output logic       init_done,
    output logic       busy
);

    localparam int            CW      = $clog2(INIT_CLKS + 1);
    localparam logic [CW-1:0] INIT_TC = CW'(INIT_CLKS);

    state_t        state, state_nxt;
    logic          pend, pend_nxt;
    logic [7:0]    pend_div, pend_div_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          init_hit;

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        pend_div_nxt = pend_div;
        count_nxt    = count;
        init_hit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_div_upd) begin
                    pend_div_nxt = cfg_clk_div;
                    state_nxt    = ST_LOAD;
                end else if (cfg_init_start) begin
                    count_nxt = '0;
                    state_nxt = ST_INIT;
                end else if (cfg_clk_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_div_upd) begin
                    pend_div_nxt = cfg_clk_div;
                    pend_nxt     = 1'b1;
                    state_nxt    = ST_DRAIN;
                end else if (!cfg_clk_en) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cfg_div_upd) begin
                    pend_div_nxt = cfg_clk_div;
                    pend_nxt     = 1'b1;
                end
                if (!gen_clk_oe) begin
                    state_nxt = pend_nxt ? ST_LOAD : ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_div_upd) begin
                    pend_div_nxt = cfg_clk_div;
                    pend_nxt     = 1'b1;
                    state_nxt    = ST_DRAIN;
                end else begin
                    state_nxt = cfg_clk_en ? ST_RUN : ST_IDLE;
                end
            end
            ST_INIT: begin
                if (cfg_div_upd) begin
                    pend_div_nxt = cfg_clk_div;
                    pend_nxt     = 1'b1;
                end
                if (gen_rx_en && (count != INIT_TC)) begin
                    count_nxt = count + 1'b1;
                end
                if (count_nxt == INIT_TC) begin
                    init_hit  = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge sd_clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            pend       <= 1'b0;
            pend_div   <= DIV_RESET;
            count      <= '0;
            sd_clk_en  <= 1'b0;
            sd_clk_div <= DIV_RESET;
            upd_done   <= 1'b0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_div  <= pend_div_nxt;
            count     <= count_nxt;
            pend      <= (state_nxt == ST_LOAD) ? 1'b0 : pend_nxt;
            sd_clk_en <= (state_nxt == ST_RUN) || (state_nxt == ST_INIT);
            busy      <= (state_nxt == ST_DRAIN) || (state_nxt == ST_LOAD) ||
                         (state_nxt == ST_INIT);
            upd_done  <= (state_nxt == ST_LOAD);
            init_done <= init_hit;
            // LOAD is only entered with the clock parked, so the divider never moves mid-toggle.
            if (state_nxt == ST_LOAD) begin
                sd_clk_div <= pend_div_nxt;
            end
        end
    end

`ifdef SDIO_CLK_AUTO_PAUSE_EN
    always_ff @(posedge sd_clk) begin
        if (!rstn) begin
            sd_clk_pause <= 1'b0;
        end else begin
            sd_clk_pause <= (state == ST_RUN) &&
                            ((rx_active && rx_fifo_full) || (tx_active && tx_fifo_empty));
        end
    end
`else
    always_ff @(posedge sd_clk) begin
        sd_clk_pause <= 1'b0;
    end

    logic unused_flow;
    assign unused_flow = ^{rx_active, tx_active, rx_fifo_full, tx_fifo_empty};
`endif

endmodule
